// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing, derived totals/sync windows and colour-bar constants
// for the VGA scan controller (colour bars enabled by VGA_COLOR_BAR_EN).
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE_D        = 640;
  localparam int unsigned H_FP_D            = 16;
  localparam int unsigned H_SYNC_D          = 96;
  localparam int unsigned H_BP_D            = 48;
  localparam int unsigned V_ACTIVE_D        = 480;
  localparam int unsigned V_FP_D            = 10;
  localparam int unsigned V_SYNC_D          = 2;
  localparam int unsigned V_BP_D            = 33;
  localparam int unsigned PATTERN_LATENCY_D = 1;

  localparam int unsigned H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int unsigned V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;
  localparam int unsigned HS_START_D = H_ACTIVE_D + H_FP_D;
  localparam int unsigned HS_END_D   = HS_START_D + H_SYNC_D - 1;
  localparam int unsigned VS_START_D = V_ACTIVE_D + V_FP_D;
  localparam int unsigned VS_END_D   = VS_START_D + V_SYNC_D - 1;

  localparam int unsigned BAR_WIDTH = 80;
  localparam logic [9:0]  BAR_ON    = 10'h3FF;
  // {R,G,B} per bar, bar 0 in the low bits: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [23:0] BAR_TABLE = {3'b000, 3'b001, 3'b100, 3'b101,
                                       3'b010, 3'b011, 3'b110, 3'b111};

  function automatic logic [2:0] bar_rgb(input logic [9:0] x);
    logic [9:0] idx;
    idx = x / 10'(BAR_WIDTH);
    return BAR_TABLE[3*idx[2:0] +: 3];
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous active-low clear to a chosen value;
// DEPTH of 0 degenerates to a wire.
module vga_delay_line #(
  parameter int unsigned      WIDTH   = 3,
  parameter int unsigned      DEPTH   = 1,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_clr_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign o_q = i_d;
    end else begin : g_sr
      logic [WIDTH-1:0] r_sr [DEPTH];

      always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
          for (int k = 0; k < DEPTH; k++) r_sr[k] <= CLR_VAL;
        end else begin
          r_sr[0] <= i_d;
          for (int k = 1; k < DEPTH; k++) r_sr[k] <= r_sr[k-1];
        end
      end

      assign o_q = r_sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA scan controller: pixel counters, registered coordinates, latency-aligned
// sync/blank/RGB. Define VGA_COLOR_BAR_EN to replace the RGB input with 8 colour bars.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE        = H_ACTIVE_D,
  parameter int unsigned H_FP            = H_FP_D,
  parameter int unsigned H_SYNC          = H_SYNC_D,
  parameter int unsigned H_BP            = H_BP_D,
  parameter int unsigned V_ACTIVE        = V_ACTIVE_D,
  parameter int unsigned V_FP            = V_FP_D,
  parameter int unsigned V_SYNC          = V_SYNC_D,
  parameter int unsigned V_BP            = V_BP_D,
  parameter int unsigned PATTERN_LATENCY = PATTERN_LATENCY_D
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic [9:0] iRed,
  input  logic [9:0] iGreen,
  input  logic [9:0] iBlue,
  output logic [9:0] oCurrent_X,
  output logic [9:0] oCurrent_Y,
  output logic       oRequest,
  output logic [9:0] oVGA_R,
  output logic [9:0] oVGA_G,
  output logic [9:0] oVGA_B,
  output logic       oVGA_HS,
  output logic       oVGA_VS,
  output logic       oVGA_BLANK_n,
  output logic       oVGA_SYNC_n,
  output logic       oFrame_Start
);

  localparam logic [9:0] C_H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] C_V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] C_H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] C_V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] C_HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] C_HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] C_VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] C_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] r_h_cnt, r_v_cnt;
  logic [9:0] r_cur_x, r_cur_y;
  logic       r_req, r_hs0, r_vs0, r_frame_start;
  logic       w_h_act, w_v_act;

  assign w_h_act = (r_h_cnt < C_H_ACT);
  assign w_v_act = (r_v_cnt < C_V_ACT);

  // The counters hold the pixel that the next edge publishes as stage 0,
  // so the first cycle after reset release already shows (0,0).
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_cur_x       <= '0;
      r_cur_y       <= '0;
      r_req         <= 1'b0;
      r_hs0         <= 1'b1;
      r_vs0         <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_cur_x       <= w_h_act ? r_h_cnt : '0;
      r_cur_y       <= w_v_act ? r_v_cnt : '0;
      r_req         <= w_h_act && w_v_act;
      r_hs0         <= !((r_h_cnt >= C_HS_START) && (r_h_cnt <= C_HS_END));
      r_vs0         <= !((r_v_cnt >= C_VS_START) && (r_v_cnt <= C_VS_END));
      r_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
      if (r_h_cnt == C_H_LAST) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == C_V_LAST) ? '0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  logic w_hs_d, w_vs_d, w_act_d;

`ifdef VGA_COLOR_BAR_EN
  logic [9:0] w_x_d;
  logic [2:0] w_bar;

  vga_delay_line #(
    .WIDTH  (13),
    .DEPTH  (PATTERN_LATENCY),
    .CLR_VAL({10'd0, 3'b110})
  ) u_dly (
    .i_clk  (iVGA_CLK),
    .i_clr_n(iRST_n),
    .i_d    ({r_cur_x, r_hs0, r_vs0, r_req}),
    .o_q    ({w_x_d, w_hs_d, w_vs_d, w_act_d})
  );

  assign w_bar = bar_rgb(w_x_d);
`else
  vga_delay_line #(
    .WIDTH  (3),
    .DEPTH  (PATTERN_LATENCY),
    .CLR_VAL(3'b110)
  ) u_dly (
    .i_clk  (iVGA_CLK),
    .i_clr_n(iRST_n),
    .i_d    ({r_hs0, r_vs0, r_req}),
    .o_q    ({w_hs_d, w_vs_d, w_act_d})
  );
`endif

  logic [9:0] r_vga_r, r_vga_g, r_vga_b;
  logic       r_vga_hs, r_vga_vs, r_vga_blank_n;

  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      r_vga_r       <= '0;
      r_vga_g       <= '0;
      r_vga_b       <= '0;
      r_vga_hs      <= 1'b1;
      r_vga_vs      <= 1'b1;
      r_vga_blank_n <= 1'b0;
    end else begin
      r_vga_hs      <= w_hs_d;
      r_vga_vs      <= w_vs_d;
      r_vga_blank_n <= w_act_d;
`ifdef VGA_COLOR_BAR_EN
      r_vga_r <= (w_act_d && w_bar[2]) ? BAR_ON : '0;
      r_vga_g <= (w_act_d && w_bar[1]) ? BAR_ON : '0;
      r_vga_b <= (w_act_d && w_bar[0]) ? BAR_ON : '0;
`else
      r_vga_r <= w_act_d ? iRed   : '0;
      r_vga_g <= w_act_d ? iGreen : '0;
      r_vga_b <= w_act_d ? iBlue  : '0;
`endif
    end
  end

  assign oCurrent_X   = r_cur_x;
  assign oCurrent_Y   = r_cur_y;
  assign oRequest     = r_req;
  assign oFrame_Start = r_frame_start;
  assign oVGA_R       = r_vga_r;
  assign oVGA_G       = r_vga_g;
  assign oVGA_B       = r_vga_b;
  assign oVGA_HS      = r_vga_hs;
  assign oVGA_VS      = r_vga_vs;
  assign oVGA_BLANK_n = r_vga_blank_n;
  assign oVGA_SYNC_n  = 1'b1;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: arithmetic frame model checked every cycle plus literal
// pins. Vertical timing is shortened (8/2/2/3 lines) so whole frames fit the run.
module tb_vga_timing_ctrl;

  localparam int HA = 640, HT = 800, HSS = 656, HSE = 751;
  localparam int VA = 8, VT = 15, VSS = 10, VSE = 11;
  localparam int FR = HT * VT;
  localparam int L  = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] i_red = '0, i_green = '0, i_blue = '0;
  logic [9:0] cur_x, cur_y, vga_r, vga_g, vga_b;
  logic       req, vga_hs, vga_vs, blank_n, sync_n, frame_start;

  vga_timing_ctrl #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .PATTERN_LATENCY(L)
  ) dut (
    .iVGA_CLK    (clk),
    .iRST_n      (rst_n),
    .iRed        (i_red),
    .iGreen      (i_green),
    .iBlue       (i_blue),
    .oCurrent_X  (cur_x),
    .oCurrent_Y  (cur_y),
    .oRequest    (req),
    .oVGA_R      (vga_r),
    .oVGA_G      (vga_g),
    .oVGA_B      (vga_b),
    .oVGA_HS     (vga_hs),
    .oVGA_VS     (vga_vs),
    .oVGA_BLANK_n(blank_n),
    .oVGA_SYNC_n (sync_n),
    .oFrame_Start(frame_start)
  );

  always #20 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int m_n = -1;       // cycle index since reset release, -1 while in reset
  bit chk_en = 1'b0;
  int hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$], fs_cyc[$];
  bit prev_hs = 1'b1, prev_vs = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d (0x%0h), want %0d (0x%0h)", name, m_n, act, act, exp, exp);
    end
  endtask

  function automatic int hpos(input int n); return (n % FR) % HT; endfunction
  function automatic int vpos(input int n); return (n % FR) / HT; endfunction
  function automatic bit act(input int n);
    return (n >= 0) && (hpos(n) < HA) && (vpos(n) < VA);
  endfunction
  function automatic int xc(input int n);
    return (n >= 0 && hpos(n) < HA) ? hpos(n) : 0;
  endfunction
  function automatic int yc(input int n);
    return (n >= 0 && vpos(n) < VA) ? vpos(n) : 0;
  endfunction

  // Expected DAC colour for the pixel the output stage shows at cycle index k+L+1
  function automatic int exp_col(input int k, input int c);
    int x;
    if (!act(k)) return 0;
    x = xc(k);
`ifdef VGA_COLOR_BAR_EN
    case (x / 80)
      0: return 'h3FF;
      1: return (c == 2) ? 0 : 'h3FF;
      2: return (c == 0) ? 0 : 'h3FF;
      3: return (c == 1) ? 'h3FF : 0;
      4: return (c == 1) ? 0 : 'h3FF;
      5: return (c == 0) ? 'h3FF : 0;
      6: return (c == 2) ? 'h3FF : 0;
      default: return 0;
    endcase
`else
    if (c == 0) return x;
    if (c == 1) return yc(k);
    return (x ^ yc(k) ^ 'h155) & 'h3FF;
`endif
  endfunction

  task automatic step();
    int k;
    @(posedge clk);
    m_n = rst_n ? m_n + 1 : -1;
    #1;
    if (m_n >= 0) begin
      if (prev_hs && !vga_hs) hs_fall.push_back(m_n);
      if (!prev_hs && vga_hs) hs_rise.push_back(m_n);
      if (prev_vs && !vga_vs) vs_fall.push_back(m_n);
      if (!prev_vs && vga_vs) vs_rise.push_back(m_n);
      if (frame_start) fs_cyc.push_back(m_n);
    end
    prev_hs = vga_hs;
    prev_vs = vga_vs;
    k = m_n - L;
`ifdef VGA_COLOR_BAR_EN
    i_red = 10'h155; i_green = 10'h155; i_blue = 10'h155;
`else
    i_red   = 10'(xc(k));
    i_green = 10'(yc(k));
    i_blue  = 10'((xc(k) ^ yc(k) ^ 'h155) & 'h3FF);
`endif
  endtask

  // Per-cycle compare against the frame model
  initial begin
    int n, k;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        n = m_n;
        k = n - L - 1;
        check("cur_x", int'(cur_x), (n < 0) ? 0 : xc(n));
        check("cur_y", int'(cur_y), (n < 0) ? 0 : yc(n));
        check("request", int'(req), int'(act(n)));
        check("frame_start", int'(frame_start), int'(n >= 0 && n % FR == 0));
        check("vga_hs", int'(vga_hs), (k < 0) ? 1 : int'(!(hpos(k) >= HSS && hpos(k) <= HSE)));
        check("vga_vs", int'(vga_vs), (k < 0) ? 1 : int'(!(vpos(k) >= VSS && vpos(k) <= VSE)));
        check("blank_n", int'(blank_n), int'(act(k)));
        check("sync_n", int'(sync_n), 1);
        check("vga_r", int'(vga_r), exp_col(k, 0));
        check("vga_g", int'(vga_g), exp_col(k, 1));
        check("vga_b", int'(vga_b), exp_col(k, 2));
      end
    end
  end

  initial begin
    int bad;
    chk_en = 1'b1;
    repeat (5) step();
    check("rst_hs", int'(vga_hs), 1);
    check("rst_vs", int'(vga_vs), 1);
    check("rst_blank_n", int'(blank_n), 0);
    check("rst_frame_start", int'(frame_start), 0);

    rst_n = 1'b1;
    step();
    check("first_x", int'(cur_x), 0);
    check("first_y", int'(cur_y), 0);
    check("first_request", int'(req), 1);
    check("first_frame_start", int'(frame_start), 1);

    bad = 0;
    for (int i = 0; i < 33500; i++) begin
      step();
`ifdef VGA_COLOR_BAR_EN
      if (m_n == 2) check("bar_px0_r", int'(vga_r), 'h3FF);
      if (m_n == 87) begin
        check("bar_px85_r", int'(vga_r), 'h3FF);
        check("bar_px85_g", int'(vga_g), 'h3FF);
        check("bar_px85_b", int'(vga_b), 0);
      end
      if (m_n == 641) check("bar_px639_rgb", int'({vga_r, vga_g, vga_b}), 0);
`else
      if (m_n == 2)   check("echo_x0", int'(vga_r), 0);
      if (m_n == 321) check("echo_x319", int'(vga_r), 319);
      if (m_n == 641) check("echo_x639", int'(vga_r), 639);
`endif
      if (m_n >= 642 && m_n <= 801 && vga_r != 0) bad++;
    end
    check("r_zero_hblank", bad, 0);

    check("hs_fall_count", int'(hs_fall.size() >= 2 && hs_rise.size() >= 1), 1);
    if (hs_fall.size() >= 2 && hs_rise.size() >= 1) begin
      check("hs_first_fall", hs_fall[0], 658);
      check("hs_low_width", hs_rise[0] - hs_fall[0], 96);
      check("hs_period", hs_fall[1] - hs_fall[0], 800);
    end
    check("vs_fall_count", int'(vs_fall.size() >= 2 && vs_rise.size() >= 1), 1);
    if (vs_fall.size() >= 2 && vs_rise.size() >= 1) begin
      check("vs_first_fall", vs_fall[0], 8002);
      check("vs_low_width", vs_rise[0] - vs_fall[0], 1600);
      check("vs_period", vs_fall[1] - vs_fall[0], 12000);
    end
    check("fs_count", fs_cyc.size(), 3);
    if (fs_cyc.size() == 3) begin
      check("fs_period_1", fs_cyc[1] - fs_cyc[0], 12000);
      check("fs_period_2", fs_cyc[2] - fs_cyc[1], 12000);
    end

    // h=700, v=11 of the third frame: inside vertical sync
    check("pre_reset_vs", int'(vga_vs), 0);
    rst_n = 1'b0;
    step();
    check("midrst_hs", int'(vga_hs), 1);
    check("midrst_vs", int'(vga_vs), 1);
    check("midrst_x", int'(cur_x), 0);
    check("midrst_y", int'(cur_y), 0);
    hs_fall.delete(); hs_rise.delete(); vs_fall.delete(); vs_rise.delete(); fs_cyc.delete();
    prev_hs = 1'b1;
    prev_vs = 1'b1;
    rst_n = 1'b1;
    repeat (12001) step();
    check("post_fs_count", fs_cyc.size(), 2);
    if (fs_cyc.size() == 2) begin
      check("post_fs_first", fs_cyc[0], 0);
      check("post_fs_second", fs_cyc[1], 12000);
    end
    check("post_vs_count", vs_fall.size(), 1);
    if (vs_fall.size() == 1) check("post_vs_fall", vs_fall[0], 8002);
    if (hs_fall.size() >= 1) check("post_hs_fall", hs_fall[0], 658);
    else check("post_hs_count", hs_fall.size(), 15);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
